// File: rtl/matrix_tx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_tx_sequencer                                                  |
// | Streams a header byte, then a row-major result matrix MSB-first, one |
// | byte per transmitter handshake.                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module matrix_tx_sequencer #(
    parameter int          ROWS     = 4,
    parameter int          COLS     = 4,
    parameter int          DATA_W   = 16,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                go,
    output logic                                                active,
    output logic                                                done,
    output logic                                                mem_rd_en,
    output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] mem_addr,
    input  logic [DATA_W-1:0]                                   mem_rdata,
    output logic [7:0]                                          tx_data,
    output logic                                                tx_start,
    input  logic                                                tx_busy
);

    localparam int c_aw = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;
    localparam int c_nb = DATA_W / 8;
    localparam int c_bw = $clog2(c_nb + 1);
    localparam logic [c_bw-1:0] c_nb_cnt    = c_bw'(c_nb);
    localparam logic [c_aw-1:0] c_last_elem = c_aw'(ROWS*COLS - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HDR     = 4'd1,
        S_RD      = 4'd2,
        S_RD_WAIT = 4'd3,
        S_LOAD    = 4'd4,
        S_SEND    = 4'd5,
        S_WAIT_HI = 4'd6,
        S_WAIT_LO = 4'd7,
        S_NEXT    = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [c_aw-1:0]     elem_q,  elem_d;
    logic [c_bw-1:0]     byte_q,  byte_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [7:0]          txd_q,   txd_d;
    logic                hdr_q,   hdr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            txd_q   <= 8'h00;
            hdr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            hdr_q   <= hdr_d;
        end
    end

    // byte_q counts bytes already loaded from the current element, so the
    // element is exhausted once it equals the bytes-per-element count.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        hdr_d   = hdr_q;
        case (state_q)
            S_IDLE: begin
                if (go && !tx_busy) state_d = S_HDR;
            end
            S_HDR: begin
                txd_d   = HDR_BYTE;
                elem_d  = '0;
                byte_d  = '0;
                hdr_d   = 1'b1;
                state_d = S_SEND;
            end
            S_SEND:    state_d = S_WAIT_HI;
            S_WAIT_HI: if (tx_busy)  state_d = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) state_d = S_NEXT;
            S_NEXT: begin
                if (hdr_q) begin
                    hdr_d   = 1'b0;
                    state_d = S_RD;
                end else if (byte_q != c_nb_cnt) begin
                    state_d = S_LOAD;
                end else if (elem_q != c_last_elem) begin
                    elem_d  = elem_q + 1'b1;
                    byte_d  = '0;
                    state_d = S_RD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_RD:      state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                shreg_d = mem_rdata;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                txd_d   = shreg_q[DATA_W-1 -: 8];
                shreg_d = shreg_q << 8;
                byte_d  = byte_q + 1'b1;
                state_d = S_SEND;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign active    = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_rd_en = (state_q == S_RD);
    assign tx_start  = (state_q == S_SEND);
    assign mem_addr  = elem_q;
    assign tx_data   = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_tx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matrix_tx_sequencer                                               |
// | Scoreboard bench: 2x2x16 instance and 1x1x8 instance.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_matrix_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go_a, go_b, ext_busy;
    logic        active_a, done_a, rd_a, start_a, busy_a;
    logic [1:0]  addr_a;
    logic [15:0] rdata_a;
    logic [7:0]  txd_a;
    logic        active_b, done_b, rd_b, start_b, busy_b;
    logic [0:0]  addr_b;
    logic [7:0]  rdata_b;
    logic [7:0]  txd_b;

    int n_vec  = 0;
    int n_fail = 0;
    int cnt_a, cnt_b;
    int st_a = 0, st_b = 0, dn_a = 0, dn_b = 0, rdc_b = 0;
    logic [7:0] held_a, held_b;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [15:0] mem_a [4];
    logic [7:0]  frame_a [9];

    matrix_tx_sequencer #(.ROWS(2), .COLS(2), .DATA_W(16), .HDR_BYTE(8'hA5)) u_dut_a (
        .clk(clk), .rst(rst), .go(go_a), .active(active_a), .done(done_a),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .tx_data(txd_a), .tx_start(start_a), .tx_busy(busy_a));

    matrix_tx_sequencer #(.ROWS(1), .COLS(1), .DATA_W(8), .HDR_BYTE(8'hA5)) u_dut_b (
        .clk(clk), .rst(rst), .go(go_b), .active(active_b), .done(done_b),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .tx_data(txd_b), .tx_start(start_b), .tx_busy(busy_b));

    // Transmitter models: busy for 10 cycles after each start.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_a <= 0;
        else if (start_a) cnt_a <= 10;
        else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_b <= 0;
        else if (start_b) cnt_b <= 10;
        else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    end
    assign busy_a = (cnt_a != 0) || ext_busy;
    assign busy_b = (cnt_b != 0);

    // Result-buffer models with one cycle of read latency.
    always @(posedge clk) if (rd_a) rdata_a <= mem_a[addr_a];
    always @(posedge clk) if (rd_b) rdata_b <= 8'h3C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A: scoreboard pop on every tx_start, hold check while busy.
    initial forever begin
        @(negedge clk);
        if (start_a) begin
            st_a++;
            held_a = txd_a;
            if (q_a.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL byte_a: got unexpected tx_start with %0h, expected none", txd_a);
            end else begin
                check("byte_a", 32'(txd_a), 32'(q_a.pop_front()));
            end
        end else if (cnt_a != 0) begin
            check("hold_a", 32'(txd_a), 32'(held_a));
        end
        if (done_a) dn_a++;
    end

    initial forever begin
        @(negedge clk);
        if (start_b) begin
            st_b++;
            held_b = txd_b;
            if (q_b.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL byte_b: got unexpected tx_start with %0h, expected none", txd_b);
            end else begin
                check("byte_b", 32'(txd_b), 32'(q_b.pop_front()));
            end
        end else if (cnt_b != 0) begin
            check("hold_b", 32'(txd_b), 32'(held_b));
        end
        if (rd_b) begin
            rdc_b++;
            check("rd_addr_b", 32'(addr_b), 32'd0);
        end
        if (done_b) dn_b++;
    end

    task automatic push_frame_a();
        for (int i = 0; i < 9; i++) q_a.push_back(frame_a[i]);
    endtask

    task automatic pulse_go_a();
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel_b ? done_b : done_a) begin
                hit = 1'b1;
                break;
            end
        end
        check(sel_b ? "done_b_seen" : "done_a_seen", 32'(hit), 32'd1);
    endtask

    task automatic wait_starts_a(input int n, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (st_a >= n) begin
                hit = 1'b1;
                break;
            end
        end
        check("starts_a_reached", 32'(hit), 32'd1);
    endtask

    task automatic check_reset_a();
        check("rst_active_a", 32'(active_a), 32'd0);
        check("rst_done_a",   32'(done_a),   32'd0);
        check("rst_rd_a",     32'(rd_a),     32'd0);
        check("rst_addr_a",   32'(addr_a),   32'd0);
        check("rst_start_a",  32'(start_a),  32'd0);
        check("rst_txd_a",    32'(txd_a),    32'd0);
    endtask

    task automatic check_frame_end_a(input string tag, input int st0, input int dn0);
        check({tag, "_starts"}, 32'(st_a - st0), 32'd9);
        check({tag, "_dones"},  32'(dn_a - dn0), 32'd1);
        check({tag, "_qempty"}, 32'(q_a.size()), 32'd0);
        check({tag, "_idle"},   32'(active_a),   32'd0);
    endtask

    initial begin
        int st0, dn0;
        mem_a    = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        frame_a  = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        rdata_a  = '0;
        rdata_b  = '0;
        rst      = 1'b1;
        go_a     = 1'b0;
        go_b     = 1'b0;
        ext_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a();
        check("rst_txd_b",   32'(txd_b),   32'd0);
        check("rst_start_b", 32'(start_b), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame with a 10-cycle busy transmitter.
        st0 = st_a; dn0 = dn_a;
        push_frame_a();
        pulse_go_a();
        wait_done(1'b0, 1000);
        @(negedge clk);
        check_frame_end_a("basic", st0, dn0);

        // go pulsed mid-frame and during the DONE cycle.
        st0 = st_a; dn0 = dn_a;
        push_frame_a();
        pulse_go_a();
        wait_starts_a(st0 + 3, 500);
        check("mid_active_a", 32'(active_a), 32'd1);
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        wait_done(1'b0, 1000);
        go_a = 1'b1;
        @(posedge clk);
        #1 go_a = 1'b0;
        repeat (300) @(negedge clk);
        check_frame_end_a("rego", st0, dn0);

        // Reset after the third byte's tx_start, then a clean restart.
        dn0 = dn_a;
        push_frame_a();
        pulse_go_a();
        wait_starts_a(st_a + 3, 500);
        rst = 1'b1;
        #1;
        check_reset_a();
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("abort_no_done", 32'(dn_a - dn0), 32'd0);
        check("abort_idle",    32'(active_a),   32'd0);
        st0 = st_a; dn0 = dn_a;
        push_frame_a();
        pulse_go_a();
        wait_done(1'b0, 1000);
        @(negedge clk);
        check_frame_end_a("restart", st0, dn0);

        // go held while the transmitter is busy.
        st0 = st_a; dn0 = dn_a;
        ext_busy = 1'b1;
        go_a     = 1'b1;
        repeat (20) @(negedge clk);
        check("busy_no_start",  32'(st_a - st0), 32'd0);
        check("busy_no_active", 32'(active_a),   32'd0);
        push_frame_a();
        ext_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (active_a) break;
        end
        go_a = 1'b0;
        check("busy_accept", 32'(active_a), 32'd1);
        wait_done(1'b0, 1000);
        @(negedge clk);
        check_frame_end_a("busygo", st0, dn0);

        // Single 8-bit element instance.
        st0 = st_b; dn0 = dn_b;
        q_b.push_back(8'hA5);
        q_b.push_back(8'h3C);
        go_b = 1'b1;
        @(negedge clk);
        go_b = 1'b0;
        wait_done(1'b1, 500);
        @(negedge clk);
        check("b_starts", 32'(st_b - st0), 32'd2);
        check("b_dones",  32'(dn_b - dn0), 32'd1);
        check("b_reads",  32'(rdc_b),      32'd1);
        check("b_qempty", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
